// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: four-channel TDM serial receiver.
// It hunts for fsync, locks on, and delivers each complete frame as parallel channel data.
module tdm_demux_rx #(
    parameter int DW  = 8,
    parameter int NCH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sd,
    input  logic              fsync,
    input  logic              bit_en,
    output logic [NCH*DW-1:0] ch_data,
    output logic              frame_valid,
    output logic              locked,
    output logic [1:0]        slot,
    output logic              sync_err
);
    localparam int FW = NCH * DW;
    localparam int CW = $clog2(FW);
    localparam logic [CW-1:0] LAST = CW'(FW - 1);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t        state;
    logic [CW-1:0] bcnt;
    logic [FW-1:0] sh;
    logic [FW-1:0] nxt;
    logic [FW-1:0] first;
    logic [CW-1:0] pos;

    // Frame bit bcnt lands in channel bcnt/DW, filling that channel MSB first.
    always_comb begin
        pos      = CW'((int'(bcnt) / DW) * DW + DW - 1 - int'(bcnt) % DW);
        nxt      = sh;
        nxt[pos] = sd;
        first    = FW'(sd) << (DW - 1);
    end

    assign locked = state == LOCK;
    assign slot   = 2'(int'(bcnt) / DW);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HUNT;
            bcnt        <= '0;
            sh          <= '0;
            ch_data     <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (bit_en) begin
                if (state == HUNT) begin
                    if (fsync) begin
                        state <= LOCK;
                        bcnt  <= CW'(1);
                        sh    <= first;
                    end
                end else if (fsync) begin
                    // An fsync anywhere but bit 0 restarts the frame here.
                    sync_err <= bcnt != '0;
                    bcnt     <= CW'(1);
                    sh       <= first;
                end else if (bcnt == '0) begin
                    sync_err <= 1'b1;
                    state    <= HUNT;
                end else begin
                    sh <= nxt;
                    if (bcnt == LAST) begin
                        ch_data     <= nxt;
                        frame_valid <= 1'b1;
                        bcnt        <= '0;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb_tdm_demux_rx: checks tdm_demux_rx (DW=8) against a bit-queue model of the receiver.
// It covers directed framing scenarios and a randomized stream.
module tb_tdm_demux_rx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sd = 1'b0;
    logic        fsync = 1'b0;
    logic        bit_en = 1'b0;
    logic [31:0] ch_data;
    logic        frame_valid;
    logic        locked;
    logic [1:0]  slot;
    logic        sync_err;

    int nvec = 0;
    int nerr = 0;

    logic        m_lock = 1'b0;
    logic        q[$];
    logic [31:0] m_data = '0;
    logic        m_fv = 1'b0;
    logic        m_se = 1'b0;

    tdm_demux_rx #(.DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .sd(sd), .fsync(fsync), .bit_en(bit_en),
        .ch_data(ch_data), .frame_valid(frame_valid), .locked(locked),
        .slot(slot), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] mexp();
        return {m_data, m_fv, m_se, m_lock, m_lock ? 2'(q.size() / 8) : 2'd0};
    endfunction

    // Bit i of a frame: channel i/8, sent MSB first.
    function automatic logic fbit(input logic [31:0] f, input int i);
        logic [7:0] b;
        b = f[(i / 8) * 8 +: 8];
        return b[7 - i % 8];
    endfunction

    task automatic step(input logic r, input logic be, input logic fs, input logic d);
        logic [7:0] v;
        rst_n = r; bit_en = be; fsync = fs; sd = d;
        @(posedge clk);
        m_fv = 1'b0;
        m_se = 1'b0;
        if (!r) begin
            m_lock = 1'b0;
            q.delete();
            m_data = '0;
        end else if (be) begin
            if (!m_lock) begin
                if (fs) begin
                    m_lock = 1'b1;
                    q = {d};
                end
            end else if (fs) begin
                m_se = q.size() != 0;
                q = {d};
            end else if (q.size() == 0) begin
                m_se = 1'b1;
                m_lock = 1'b0;
            end else begin
                q.push_back(d);
                if (q.size() == 32) begin
                    for (int k = 0; k < 4; k++) begin
                        v = '0;
                        for (int j = 0; j < 8; j++) v = {v[6:0], q[k * 8 + j]};
                        m_data[k * 8 +: 8] = v;
                    end
                    m_fv = 1'b1;
                    q.delete();
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        nvec++;
        if ({ch_data, frame_valid, sync_err, locked, slot} !== 37'd0) begin
            nerr++;
            $display("FAIL reset: got %h want 0", {ch_data, frame_valid, sync_err, locked, slot});
        end
    endtask

    task automatic test_frame();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b1, i == 0, fbit(32'h01FF3CA5, i));
            nvec++;
            if ({ch_data, frame_valid, sync_err, locked, slot} !== mexp()) begin
                nerr++;
                $display("FAIL frame bit %0d: got %h want %h", i, {ch_data, frame_valid, sync_err, locked, slot}, mexp());
            end
        end
        nvec++;
        if (ch_data !== 32'h01FF3CA5 || frame_valid !== 1'b1) begin
            nerr++;
            $display("FAIL frame data: got %h fv %b want 01ff3ca5 fv 1", ch_data, frame_valid);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        nvec++;
        if (frame_valid !== 1'b0 || ch_data !== 32'h01FF3CA5) begin
            nerr++;
            $display("FAIL frame hold: got %h fv %b want 01ff3ca5 fv 0", ch_data, frame_valid);
        end
    endtask

    task automatic test_bit_en_gaps();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b1, i == 0, fbit(32'h01FF3CA5, i));
            nvec++;
            if ({ch_data, frame_valid, sync_err, locked, slot} !== mexp()) begin
                nerr++;
                $display("FAIL gap bit %0d: got %h want %h", i, {ch_data, frame_valid, sync_err, locked, slot}, mexp());
            end
            if (i == 31) begin
                nvec++;
                if (ch_data !== 32'h01FF3CA5 || frame_valid !== 1'b1) begin
                    nerr++;
                    $display("FAIL gap data: got %h fv %b want 01ff3ca5 fv 1", ch_data, frame_valid);
                end
            end
            step(1'b1, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
            nvec++;
            if ({ch_data, frame_valid, sync_err, locked, slot} !== mexp()) begin
                nerr++;
                $display("FAIL gap idle %0d: got %h want %h", i, {ch_data, frame_valid, sync_err, locked, slot}, mexp());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] f;
        for (int n = 0; n < 2; n++) begin
            f = $urandom;
            for (int i = 0; i < 32; i++) begin
                step(1'b1, 1'b1, i == 0, fbit(f, i));
                nvec++;
                if ({ch_data, frame_valid, sync_err, locked, slot} !== mexp()) begin
                    nerr++;
                    $display("FAIL b2b %0d bit %0d: got %h want %h", n, i, {ch_data, frame_valid, sync_err, locked, slot}, mexp());
                end
            end
            nvec++;
            if (ch_data !== f) begin
                nerr++;
                $display("FAIL b2b data %0d: got %h want %h", n, ch_data, f);
            end
        end
        step(1'b1, 1'b1, 1'b0, 1'b1);
        nvec++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || frame_valid !== 1'b0 || ch_data !== f) begin
            nerr++;
            $display("FAIL missing sync: got se %b lk %b fv %b %h want 1 0 0 %h", sync_err, locked, frame_valid, ch_data, f);
        end
    endtask

    task automatic test_early_sync();
        logic [31:0] f;
        logic [31:0] g;
        f = $urandom;
        g = $urandom;
        for (int i = 0; i < 13; i++) step(1'b1, 1'b1, i == 0, fbit(f, i));
        nvec++;
        if (locked !== 1'b1 || slot !== 2'd1) begin
            nerr++;
            $display("FAIL early pre: got lk %b slot %0d want 1 1", locked, slot);
        end
        step(1'b1, 1'b1, 1'b1, fbit(g, 0));
        nvec++;
        if (sync_err !== 1'b1 || frame_valid !== 1'b0 || locked !== 1'b1 || slot !== 2'd0) begin
            nerr++;
            $display("FAIL early sync: got se %b fv %b lk %b slot %0d want 1 0 1 0", sync_err, frame_valid, locked, slot);
        end
        for (int i = 1; i < 32; i++) begin
            step(1'b1, 1'b1, 1'b0, fbit(g, i));
            nvec++;
            if ({ch_data, frame_valid, sync_err, locked, slot} !== mexp()) begin
                nerr++;
                $display("FAIL early bit %0d: got %h want %h", i, {ch_data, frame_valid, sync_err, locked, slot}, mexp());
            end
        end
        nvec++;
        if (ch_data !== g || frame_valid !== 1'b1) begin
            nerr++;
            $display("FAIL early data: got %h fv %b want %h fv 1", ch_data, frame_valid, g);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] f;
        f = $urandom;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, i == 0, fbit(f, i));
        step(1'b0, 1'b1, 1'b1, 1'b1);
        nvec++;
        if ({ch_data, frame_valid, sync_err, locked, slot} !== 37'd0) begin
            nerr++;
            $display("FAIL mid reset: got %h want 0", {ch_data, frame_valid, sync_err, locked, slot});
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'($urandom_range(1)));
            nvec++;
            if ({ch_data, frame_valid, sync_err, locked, slot} !== 37'd0) begin
                nerr++;
                $display("FAIL post reset %0d: got %h want 0", i, {ch_data, frame_valid, sync_err, locked, slot});
            end
        end
        f = $urandom;
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, i == 0, fbit(f, i));
        nvec++;
        if (ch_data !== f || frame_valid !== 1'b1 || sync_err !== 1'b0) begin
            nerr++;
            $display("FAIL reset recovery: got %h fv %b se %b want %h 1 0", ch_data, frame_valid, sync_err, f);
        end
    endtask

    task automatic test_idle();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'($urandom_range(1)));
            nvec++;
            if ({ch_data, frame_valid, sync_err, locked, slot} !== 37'd0) begin
                nerr++;
                $display("FAIL idle %0d: got %h want 0", i, {ch_data, frame_valid, sync_err, locked, slot});
            end
        end
    endtask

    task automatic test_random();
        logic fs;
        for (int i = 0; i < 1500; i++) begin
            fs = (m_lock && q.size() == 0) ? ($urandom_range(9) != 0) : ($urandom_range(29) == 0);
            step($urandom_range(299) != 0, $urandom_range(3) != 0, fs, 1'($urandom_range(1)));
            nvec++;
            if ({ch_data, frame_valid, sync_err, locked, slot} !== mexp()) begin
                nerr++;
                $display("FAIL random %0d: got %h want %h", i, {ch_data, frame_valid, sync_err, locked, slot}, mexp());
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_bit_en_gaps();
        test_back_to_back();
        test_early_sync();
        test_reset_mid();
        test_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
